regfile_writer: RTL and testbench
=================================

# regfile_writer

Write-side companion of the register-file read port: collects writeback results from the ALU (fixed-latency, never stalled) and the load unit (valid/ready, variable latency) and issues them one per cycle to the 32×32 register array's single write port. ALU results have priority; load results are buffered in a small in-order queue. A per-register pending lookup lets decode interlock reads against queued writes.

## Interface
- `DEPTH`, default 4: load-result queue entries; power of two, ≥2
- `clk` input, 1: rising-edge clock
- `reset` input, 1: synchronous, active-high
- `alu_valid` input, 1: ALU result present this cycle; always accepted
- `alu_rd` input, 5: ALU destination index
- `alu_data` input, 32: ALU result
- `mem_valid` input, 1: load result offered
- `mem_ready` output, 1: queue can accept; transfer when `mem_valid && mem_ready`
- `mem_rd` input, 5: load destination index
- `mem_data` input, 32: load result
- `wr_en` output, 1: register-array write strobe
- `wr_index` output, 5: write address
- `wr_data` output, 32: write data
- `rs1_index`, `rs2_index` input, 5 each: decode-stage read indices
- `rs1_pending`, `rs2_pending` output, 1 each: a queued or in-flight write targets that index

## Operation
- Writes to index 0 from either source are dropped at the input: no queue entry, no `wr_en`.
- ALU: if `alu_valid` and `alu_rd != 0`, the output stage loads {1, `alu_rd`, `alu_data`} at the next edge.
- Load: accepted transfers with `mem_rd != 0` push {valid, rd, data} at the queue tail.
- Drain: when the ALU does not claim the output stage this cycle and the queue is non-empty, the head is popped into the output stage. A killed head is popped with `wr_en` = 0.
- Kill: an accepted ALU write to rd clears the valid bit of every queued entry with the same rd. The ALU result is younger in program order, so the stale load must not overwrite it.
- Pending: `rsN_pending` = (any queue entry valid with rd == `rsN_index`) OR (`wr_en` && `wr_index` == `rsN_index`). It is combinational from state and indices, and is 0 for index 0.
- `mem_ready` = (count < DEPTH), computed from registered count only. There is no same-cycle pop credit.

## Timing
- Reset values: `wr_en`=0, `wr_index`=0, `wr_data`=0, queue empty, count=0, `mem_ready`=1 (from the cycle after reset deasserts; 0 while `reset` is high), pending outputs 0.
- ALU latency: 1 cycle, input edge to `wr_en`.
- Load latency: minimum 2 cycles (push, then pop) when the ALU is idle. Otherwise it waits while the ALU holds the port.
- Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.
- Full: `mem_ready`=0, and `mem_valid` is ignored. A pop that same cycle does not raise ready until the next cycle.
- Empty with no ALU request: `wr_en`=0, and `wr_index`/`wr_data` hold their last values.
- ALU write and same-rd load push in the same cycle: the load is younger, so it is queued unkilled; the ALU write issues first.
- Reset mid-operation: all queued entries are discarded and the output stage is cleared the next edge; no partial writes.
- Exactly one write per cycle; continuous ALU traffic can starve the queue (upstream guarantees ALU bubbles).

## Structure
- Shared package: `REG_COUNT`=32, `REG_IDX_W`=5, `XLEN`=32, and a writeback-entry struct {valid, rd, data}.
- Sub-module `wb_queue`: DEPTH-entry circular FIFO with per-entry kill-by-rd input and rd-match lookup outputs.
- Top level: the priority mux, output register and pending logic.

## Test plan
- Reset, then `alu_valid` with rd=5, data=0x0000_00AA → next cycle `wr_en`=1, `wr_index`=5, `wr_data`=0xAA.
- ALU idle, load rd=7, data=0xDEAD_BEEF → `wr_en` two cycles after acceptance; `rs1_pending`=1 for index 7 until the write cycle ends.
- ALU writes every cycle for 6 cycles while 5 loads are offered → `mem_ready` drops after 4 accepted; all 4 issue in order once the ALU idles.
- Load rd=3 queued, then ALU rd=3, data=0x11 → only 0x11 is written to index 3; the killed pop shows `wr_en`=0.
- Writes to rd=0 from both sources → no `wr_en`, queue count unchanged, `rs1_pending`=0 for index 0.
- Fill the queue, assert `reset` for 1 cycle → `wr_en`=0, `mem_ready`=1 after release, no queued data written.

Source files
------------

// File: rtl/regfile_writer_pkg.sv
// ============================================================================
// regfile_writer_pkg : shared register-file widths and writeback entry type
// Revision: 1.0
// ============================================================================
`default_nettype none

package regfile_writer_pkg;

   localparam int REG_COUNT = 32;
   localparam int REG_IDX_W = 5;
   localparam int XLEN      = 32;

   typedef struct packed {
      logic                 valid;
      logic [REG_IDX_W-1:0] rd;
      logic [XLEN-1:0]      data;
   } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/regfile_writer_wb_queue.sv
// ============================================================================
// wb_queue : in-order load-result FIFO with kill-by-rd and rd-match lookups
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_queue
   import regfile_writer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push_i,
   input  wb_entry_t            push_entry_i,
   input  logic                 pop_i,
   input  logic                 kill_i,
   input  logic [REG_IDX_W-1:0] kill_rd_i,
   input  logic [REG_IDX_W-1:0] look1_rd_i,
   input  logic [REG_IDX_W-1:0] look2_rd_i,
   output wb_entry_t            head_o,
   output logic                 empty_o,
   output logic                 full_o,
   output logic                 look1_hit_o,
   output logic                 look2_hit_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   wb_entry_t        entries_q [DEPTH];
   wb_entry_t        entries_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Kill is applied before the push so a same-cycle same-rd load stays live;
   // popped slots are invalidated so stale entries never match a lookup.
   always_comb begin
      entries_d = entries_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      if (kill_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (entries_q[i].rd == kill_rd_i) begin
               entries_d[i].valid = 1'b0;
            end
         end
      end
      if (pop_i) begin
         entries_d[head_q].valid = 1'b0;
         head_d                  = head_q + 1'b1;
      end
      if (push_i) begin
         entries_d[tail_q] = push_entry_i;
         tail_d            = tail_q + 1'b1;
      end
      if (push_i && !pop_i) begin
         count_d = count_q + 1'b1;
      end else if (pop_i && !push_i) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         entries_q <= entries_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
      end
   end

   always_comb begin
      look1_hit_o = 1'b0;
      look2_hit_o = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entries_q[i].valid && entries_q[i].rd == look1_rd_i) look1_hit_o = 1'b1;
         if (entries_q[i].valid && entries_q[i].rd == look2_rd_i) look2_hit_o = 1'b1;
      end
   end

   assign head_o  = entries_q[head_q];
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/regfile_writer.sv
// ============================================================================
// regfile_writer : ALU/load writeback arbiter driving the register-array port
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_writer
   import regfile_writer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 alu_valid,
   input  logic [REG_IDX_W-1:0] alu_rd,
   input  logic [XLEN-1:0]      alu_data,
   input  logic                 mem_valid,
   output logic                 mem_ready,
   input  logic [REG_IDX_W-1:0] mem_rd,
   input  logic [XLEN-1:0]      mem_data,
   output logic                 wr_en,
   output logic [REG_IDX_W-1:0] wr_index,
   output logic [XLEN-1:0]      wr_data,
   input  logic [REG_IDX_W-1:0] rs1_index,
   input  logic [REG_IDX_W-1:0] rs2_index,
   output logic                 rs1_pending,
   output logic                 rs2_pending
);

   wb_entry_t out_q, out_d;
   wb_entry_t head;
   logic      alu_take, mem_push, q_pop;
   logic      q_empty, q_full, hit1, hit2;

   assign alu_take  = alu_valid && (alu_rd != '0);
   assign mem_ready = !reset && !q_full;
   assign mem_push  = mem_valid && mem_ready && (mem_rd != '0);
   assign q_pop     = !alu_take && !q_empty;

   wb_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk          (clk),
      .reset        (reset),
      .push_i       (mem_push),
      .push_entry_i ({1'b1, mem_rd, mem_data}),
      .pop_i        (q_pop),
      .kill_i       (alu_take),
      .kill_rd_i    (alu_rd),
      .look1_rd_i   (rs1_index),
      .look2_rd_i   (rs2_index),
      .head_o       (head),
      .empty_o      (q_empty),
      .full_o       (q_full),
      .look1_hit_o  (hit1),
      .look2_hit_o  (hit2)
   );

   // Idle cycles only drop the strobe; index and data hold their last values.
   always_comb begin
      out_d       = out_q;
      out_d.valid = 1'b0;
      if (alu_take) begin
         out_d = {1'b1, alu_rd, alu_data};
      end else if (q_pop) begin
         out_d = head;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign wr_en    = out_q.valid;
   assign wr_index = out_q.rd;
   assign wr_data  = out_q.data;

   assign rs1_pending = (rs1_index != '0) && (hit1 || (out_q.valid && out_q.rd == rs1_index));
   assign rs2_pending = (rs2_index != '0) && (hit2 || (out_q.valid && out_q.rd == rs2_index));

endmodule

`default_nettype wire

// File: tb/tb_regfile_writer.sv
// ============================================================================
// tb_regfile_writer : randomized bench against a queue-based writeback model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile_writer;
   import regfile_writer_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid, mem_valid, mem_ready;
   logic [4:0]  alu_rd, mem_rd, wr_index, rs1_index, rs2_index;
   logic [31:0] alu_data, mem_data, wr_data;
   logic        wr_en, rs1_pending, rs2_pending;

   always #5 clk = ~clk;

   regfile_writer #(
      .DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .alu_valid   (alu_valid),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .mem_valid   (mem_valid),
      .mem_ready   (mem_ready),
      .mem_rd      (mem_rd),
      .mem_data    (mem_data),
      .wr_en       (wr_en),
      .wr_index    (wr_index),
      .wr_data     (wr_data),
      .rs1_index   (rs1_index),
      .rs2_index   (rs2_index),
      .rs1_pending (rs1_pending),
      .rs2_pending (rs2_pending)
   );

   typedef struct {
      bit        v;
      bit [4:0]  rd;
      bit [31:0] d;
   } ent_t;

   int   checks = 0;
   int   errors = 0;
   ent_t mq[$];
   bit   m_wen   = 1'b0;
   bit   m_known = 1'b1;
   bit [4:0]  m_idx  = '0;
   bit [31:0] m_data = '0;
   bit   last_acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit m_pend(input bit [4:0] rs);
      if (rs == 0) return 1'b0;
      if (m_wen && m_idx == rs) return 1'b1;
      foreach (mq[i]) if (mq[i].v && mq[i].rd == rs) return 1'b1;
      return 1'b0;
   endfunction

   task automatic step(input bit rst, input bit av, input bit [4:0] ard, input bit [31:0] ad,
                       input bit mv, input bit [4:0] mrd, input bit [31:0] md,
                       input bit [4:0] r1, input bit [4:0] r2);
      bit   rdy;
      ent_t h;
      @(negedge clk);
      reset = rst; alu_valid = av; alu_rd = ard; alu_data = ad;
      mem_valid = mv; mem_rd = mrd; mem_data = md;
      rs1_index = r1; rs2_index = r2;
      #1;
      rdy = !rst && (mq.size() < DEPTH);
      chk("mem_ready", mem_ready, rdy);
      chk("rs1_pending", rs1_pending, m_pend(r1));
      chk("rs2_pending", rs2_pending, m_pend(r2));
      last_acc = !rst && mv && rdy && (mrd != 0);
      @(posedge clk);
      if (rst) begin
         mq.delete();
         m_wen = 0; m_idx = 0; m_data = 0; m_known = 1;
      end else begin
         if (av && ard != 0) begin
            foreach (mq[i]) if (mq[i].rd == ard) mq[i].v = 1'b0;
            m_wen = 1; m_idx = ard; m_data = ad; m_known = 1;
         end else if (mq.size() > 0) begin
            h = mq.pop_front();
            m_wen = h.v;
            if (h.v) begin
               m_idx = h.rd; m_data = h.d; m_known = 1;
            end else begin
               m_known = 0;
            end
         end else begin
            m_wen = 0;
         end
         if (last_acc) mq.push_back('{1'b1, mrd, md});
      end
      #1;
      chk("wr_en", wr_en, m_wen);
      if (m_known) begin
         chk("wr_index", wr_index, m_idx);
         chk("wr_data", wr_data, m_data);
      end
   endtask

   task automatic idle(input int n, input bit [4:0] r1);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, r1, 0);
   endtask

   initial begin
      int acc_cnt;
      int alu_pct;
      reset = 1'b1; alu_valid = 0; alu_rd = 0; alu_data = 0;
      mem_valid = 0; mem_rd = 0; mem_data = 0; rs1_index = 0; rs2_index = 0;
      repeat (2) @(posedge clk);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(1, 0);

      // ALU write, one-cycle latency
      step(0, 1, 5, 32'h0000_00AA, 0, 0, 0, 5, 0);
      idle(1, 5);
      chk("alu_idx_hold", wr_index, 32'd5);

      // Single load with pending interlock on index 7
      step(0, 0, 0, 0, 1, 7, 32'hDEAD_BEEF, 7, 0);
      idle(3, 7);

      // ALU busy 6 cycles while 5 loads are offered
      acc_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         step(0, 1, 5'(i + 1), 32'h100 + i, acc_cnt < 5, 5'(10 + acc_cnt), 32'h200 + acc_cnt,
              5'(10 + acc_cnt), 13);
         if (last_acc) acc_cnt++;
      end
      idle(6, 12);

      // Queued load killed by a younger ALU write to the same rd
      step(0, 1, 9, 32'h99, 1, 3, 32'h3333, 3, 0);
      step(0, 1, 3, 32'h11, 0, 0, 0, 3, 0);
      idle(3, 3);

      // Writes to x0 from both sources
      step(0, 1, 0, 32'hFFFF, 1, 0, 32'hEEEE, 0, 0);
      idle(2, 0);

      // Fill the queue, then reset mid-operation
      for (int i = 0; i < 5; i++) step(0, 1, 20, 32'h20 + i, 1, 5'(21 + i), 32'h300 + i, 21, 22);
      step(1, 0, 0, 0, 1, 25, 32'h555, 21, 22);
      idle(4, 21);

      // Randomized traffic with alternating ALU load
      for (int c = 0; c < 3000; c++) begin
         alu_pct = ((c / 150) % 2) ? 85 : 30;
         step(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 99) < alu_pct), 5'($urandom_range(0, 7)), $urandom,
              ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
      idle(8, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
